ibex_mem_arbiter: RTL and testbench
===================================

# ibex_mem_arbiter

Parametrised N-requester arbiter that merges the Ibex instruction port, data port and a host/loader port onto one single-port RAM (ram_1p). Grants one request per cycle by round-robin or fixed priority, range-checks each address, and routes every read/write response back to its originator through a latency-matched response pipeline. Out-of-range accesses get an in-order error response without touching memory. This block replaces the fixed two-port instruction/data mux in the testbench BFM.

## Interface
- NumReq, 3, number of requesters; index 0 = instr, 1 = data, 2 = host
- AddrWidth, 32, requester byte-address width
- DataWidth, 32, data width; byte enables DataWidth/8
- MemDepth, 16384, RAM depth in words
- MemBase, 32'h0000_0000, byte address of RAM word 0
- MemLatency, 1, RAM req-to-rvalid cycles (1..4)
- ArbMode, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)

- clk_i  in  1  sole clock; all state on rising edge
- rst_ni  in  1  reset, synchronous, active-low
- req_i  in  NumReq  per-requester request
- we_i  in  NumReq  per-requester write enable
- be_i  in  NumReq×DataWidth/8  byte enables
- addr_i  in  NumReq×AddrWidth  byte addresses
- wdata_i  in  NumReq×DataWidth  write data
- gnt_o  out  NumReq  grant, one-hot or zero
- rvalid_o  out  NumReq  response valid, one-hot or zero
- err_o  out  NumReq  response error, valid with rvalid_o
- rdata_o  out  DataWidth  read data, shared by all requesters
- mem_req_o  out  1  RAM request
- mem_we_o  out  1  RAM write enable
- mem_be_o  out  DataWidth/8  RAM byte enables
- mem_addr_o  out  32  RAM byte address, offset by MemBase
- mem_wdata_o  out  DataWidth  RAM write data
- mem_rvalid_i  in  1  RAM response valid
- mem_rdata_i  in  DataWidth  RAM read data
- protocol_err_o  out  1  sticky: mem_rvalid_i mismatched pipeline

## Operation
- Arbitration is combinational: gnt_o asserts in the same cycle as the winning req_i; a request completes its address phase on req&gnt.
- Round-robin: pointer holds the last granted index; search starts at pointer+1 mod NumReq; pointer updates only on a grant. Fixed priority: lowest asserted index wins; no pointer.
- Range check: in range iff MemBase ≤ addr < MemBase + 4·MemDepth (compare widened to AddrWidth+1 bits, no wrap). In range: mem_req_o=1 with granted we/be/wdata, mem_addr_o = addr − MemBase. Out of range: granted, mem_req_o=0.
- Response pipeline: MemLatency stages of {valid, id, err}; stage 0 loads on any grant.
- Pipeline exit: rvalid_o[id]=1, err_o[id]=err, rdata_o = mem_rdata_i if !err, else 0. Write responses also produce rvalid_o, with rdata_o = 0 on writes.
- Check: if exit stage is valid with !err and mem_rvalid_i=0, or mem_rvalid_i=1 without such a stage, set protocol_err_o. It clears only on reset.
- No backpressure on responses. The pipeline never stalls, so throughput is one access per cycle.

## Timing
- Reset (rst_ni=0 at a rising edge): RR pointer = NumReq−1, so index 0 wins first. Pipeline valids clear, and protocol_err_o = 0.
- While in reset, all outputs are 0: gnt_o, rvalid_o, err_o, rdata_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o.
- Grant at cycle t gives rvalid_o at t+MemLatency, both in range and out of range.
- Simultaneous requests: exactly one grant per cycle; losers hold req_i with stable address/data until granted.
- A grant and a response to different requesters in the same cycle are independent.
- Reset mid-operation drops in-flight responses silently: no rvalid_o after reset, and no protocol_err_o for the dropped ones.
- A requester dropping req_i without a grant is legal and has no effect on state.

## Test plan
- Single read: req_i=3'b001, addr 0x80, RAM word 0x20 = 0x0000_0013 -> gnt_o=001 same cycle; rvalid_o=001, rdata_o=0x13, err_o=0 one cycle later.
- Round-robin contention: req_i=3'b111 held for 6 cycles -> grants 001,010,100,001,010,100; ArbMode=1 -> 001 six times.
- Out-of-range: requester 1 writes addr 0x0001_0000 (MemDepth 16384) -> gnt_o=010, mem_req_o=0; after 1 cycle rvalid_o=010, err_o=010, rdata_o=0, RAM unchanged.
- Byte-enable write then read: host writes 0xAABBCCDD be=4'b0101 to 0x100 over 0x1111_1111 -> read returns 0x11BB11DD.
- MemLatency=3, back-to-back reads from instr then data -> rvalid_o 001 at t+3, 010 at t+4, correct data each; a spurious mem_rvalid_i pulse sets protocol_err_o.
- Reset with 2 responses in flight -> no rvalid_o afterwards, protocol_err_o=0, first grant after reset goes to index 0.

Source files
------------

// File: rtl/ibex_mem_arbiter.sv
// N-requester arbiter merging Ibex instr/data/host ports onto one single-port RAM.
// One grant per cycle (round-robin or fixed priority) with a latency-matched response pipeline.
module ibex_mem_arbiter #(
   parameter int unsigned NumReq     = 3,
   parameter int unsigned AddrWidth  = 32,
   parameter int unsigned DataWidth  = 32,
   parameter int unsigned MemDepth   = 16384,
   parameter logic [31:0] MemBase    = 32'h0000_0000,
   parameter int unsigned MemLatency = 1,
   parameter int unsigned ArbMode    = 0
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [NumReq-1:0]             req_i,
   input  logic [NumReq-1:0]             we_i,
   input  logic [NumReq*DataWidth/8-1:0] be_i,
   input  logic [NumReq*AddrWidth-1:0]   addr_i,
   input  logic [NumReq*DataWidth-1:0]   wdata_i,
   output logic [NumReq-1:0]             gnt_o,
   output logic [NumReq-1:0]             rvalid_o,
   output logic [NumReq-1:0]             err_o,
   output logic [DataWidth-1:0]          rdata_o,
   output logic                          mem_req_o,
   output logic                          mem_we_o,
   output logic [DataWidth/8-1:0]        mem_be_o,
   output logic [31:0]                   mem_addr_o,
   output logic [DataWidth-1:0]          mem_wdata_o,
   input  logic                          mem_rvalid_i,
   input  logic [DataWidth-1:0]          mem_rdata_i,
   output logic                          protocol_err_o
);

   localparam int unsigned BeW  = DataWidth / 8;
   localparam int unsigned IdW  = (NumReq > 1) ? $clog2(NumReq) : 1;
   localparam int unsigned Last = MemLatency - 1;
   localparam logic [AddrWidth:0] BaseExt  = (AddrWidth+1)'(MemBase);
   localparam logic [AddrWidth:0] LimitExt = BaseExt + (AddrWidth+1)'(64'(MemDepth) * 64'd4);

   logic [IdW-1:0]                 r_ptr;
   logic                           r_prot;
   logic [2:0]                     r_drain;
   logic [MemLatency-1:0]          r_pv;
   logic [MemLatency-1:0]          r_perr;
   logic [MemLatency-1:0]          r_pwe;
   logic [MemLatency-1:0][IdW-1:0] r_pid;

   logic                 w_gnt_any;
   logic [IdW-1:0]       w_gnt_idx;
   logic [IdW-1:0]       w_cand;
   logic [AddrWidth-1:0] w_addr;
   logic                 w_we;
   logic [BeW-1:0]       w_be;
   logic [DataWidth-1:0] w_wdata;
   logic                 w_in_range;
   logic                 w_grant;
   logic                 w_mem_go;
   logic                 w_exit_v;
   logic                 w_exit_ok;
   logic                 w_mismatch;

   // Round-robin scans from the slot after the last winner; fixed priority scans from 0.
   always_comb begin
      w_gnt_any = 1'b0;
      w_gnt_idx = '0;
      w_cand    = '0;
      for (int k = 0; k < NumReq; k++) begin
         if (ArbMode == 1) w_cand = IdW'(k);
         else              w_cand = IdW'((32'(r_ptr) + 32'(k) + 32'd1) % NumReq);
         if (!w_gnt_any && req_i[w_cand]) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = w_cand;
         end
      end
   end

   assign w_addr  = addr_i[w_gnt_idx*AddrWidth +: AddrWidth];
   assign w_we    = we_i[w_gnt_idx];
   assign w_be    = be_i[w_gnt_idx*BeW +: BeW];
   assign w_wdata = wdata_i[w_gnt_idx*DataWidth +: DataWidth];

   // Widened compare so a window touching the top of the address space cannot wrap.
   assign w_in_range = ({1'b0, w_addr} >= BaseExt) && ({1'b0, w_addr} < LimitExt);
   assign w_grant    = rst_ni & w_gnt_any;
   assign w_mem_go   = w_grant & w_in_range;

   assign gnt_o       = w_grant ? (NumReq'(1) << w_gnt_idx) : '0;
   assign mem_req_o   = w_mem_go;
   assign mem_we_o    = w_mem_go & w_we;
   assign mem_be_o    = w_mem_go ? w_be : '0;
   assign mem_addr_o  = w_mem_go ? 32'(w_addr - AddrWidth'(MemBase)) : '0;
   assign mem_wdata_o = w_mem_go ? w_wdata : '0;

   assign w_exit_v  = rst_ni & r_pv[Last];
   assign w_exit_ok = w_exit_v & ~r_perr[Last];
   // RAM responses to accesses dropped by a reset may still arrive during the drain window.
   assign w_mismatch = (w_exit_ok & ~mem_rvalid_i) |
                       (mem_rvalid_i & ~w_exit_ok & (r_drain == 3'd0));

   assign rvalid_o       = w_exit_v ? (NumReq'(1) << r_pid[Last]) : '0;
   assign err_o          = (w_exit_v & r_perr[Last]) ? (NumReq'(1) << r_pid[Last]) : '0;
   assign rdata_o        = (w_exit_ok & ~r_pwe[Last]) ? mem_rdata_i : '0;
   assign protocol_err_o = rst_ni & r_prot;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_pv    <= '0;
         r_perr  <= '0;
         r_pwe   <= '0;
         r_pid   <= '0;
         r_ptr   <= IdW'(NumReq - 1);
         r_prot  <= 1'b0;
         r_drain <= 3'(MemLatency);
      end else begin
         r_pv[0]   <= w_gnt_any;
         r_perr[0] <= ~w_in_range;
         r_pwe[0]  <= w_we;
         r_pid[0]  <= w_gnt_idx;
         for (int s = 1; s < MemLatency; s++) begin
            r_pv[s]   <= r_pv[s-1];
            r_perr[s] <= r_perr[s-1];
            r_pwe[s]  <= r_pwe[s-1];
            r_pid[s]  <= r_pid[s-1];
         end
         if (ArbMode == 0 && w_gnt_any) r_ptr <= w_gnt_idx;
         if (w_mismatch) r_prot <= 1'b1;
         if (r_drain != 3'd0) r_drain <= r_drain - 3'd1;
      end
   end

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Bench for ibex_mem_arbiter: round-robin and fixed-priority instances at latency 1,
// plus a latency-3 instance for back-to-back, protocol-error and reset-drop sequences.
module tb_ibex_mem_arbiter;

   typedef struct packed {
      logic [2:0]  rv;
      logic [2:0]  err;
      logic [31:0] rdata;
      logic [31:0] due;
   } resp_t;

   typedef struct {
      logic [2:0]  req;
      logic [2:0]  we;
      logic [3:0]  be;
      logic [31:0] a0, a1, a2, wd;
      logic [2:0]  gnt;
      logic [2:0]  fgnt;
      logic        mreq;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n, c_rst_n;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_run = 0, n_fail = 0;

   // Shared stimulus for round-robin (a) and fixed-priority (f) instances
   logic [2:0] req, we;
   logic [11:0] be;
   logic [95:0] addr, wdata;
   logic [2:0] a_gnt, a_rvalid, a_err, f_gnt, f_rvalid, f_err;
   logic [31:0] a_rdata, a_maddr, a_mwdata, f_rdata, f_maddr, f_mwdata;
   logic a_mreq, a_mwe, a_perr, f_mreq, f_mwe, f_perr;
   logic [3:0] a_mbe, f_mbe;
   logic a_mrvalid = 1'b0, f_mrvalid = 1'b0;
   logic [31:0] a_mrdata = '0;

   // Latency-3 instance
   logic [2:0] c_req, c_we;
   logic [11:0] c_be;
   logic [95:0] c_addr, c_wdata;
   logic [2:0] c_gnt, c_rvalid, c_err;
   logic [31:0] c_rdata, c_maddr, c_mwdata;
   logic c_mreq, c_mwe, c_perr, c_spur;
   logic [3:0] c_mbe;
   logic [2:0] c_rv_p = '0;
   logic [31:0] c_rd_p [3];

   logic [31:0] ram_a [0:16383];
   logic [31:0] ram_c [0:16383];
   logic [31:0] model_a [0:16383];
   resp_t exp_a[$], exp_c[$];

   ibex_mem_arbiter #(.MemLatency(1), .ArbMode(0)) u_rr (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
      .wdata_i(wdata), .gnt_o(a_gnt), .rvalid_o(a_rvalid), .err_o(a_err), .rdata_o(a_rdata),
      .mem_req_o(a_mreq), .mem_we_o(a_mwe), .mem_be_o(a_mbe), .mem_addr_o(a_maddr),
      .mem_wdata_o(a_mwdata), .mem_rvalid_i(a_mrvalid), .mem_rdata_i(a_mrdata),
      .protocol_err_o(a_perr));

   ibex_mem_arbiter #(.MemLatency(1), .ArbMode(1)) u_fp (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
      .wdata_i(wdata), .gnt_o(f_gnt), .rvalid_o(f_rvalid), .err_o(f_err), .rdata_o(f_rdata),
      .mem_req_o(f_mreq), .mem_we_o(f_mwe), .mem_be_o(f_mbe), .mem_addr_o(f_maddr),
      .mem_wdata_o(f_mwdata), .mem_rvalid_i(f_mrvalid), .mem_rdata_i(32'h0),
      .protocol_err_o(f_perr));

   ibex_mem_arbiter #(.MemLatency(3), .ArbMode(0)) u_l3 (
      .clk_i(clk), .rst_ni(c_rst_n), .req_i(c_req), .we_i(c_we), .be_i(c_be), .addr_i(c_addr),
      .wdata_i(c_wdata), .gnt_o(c_gnt), .rvalid_o(c_rvalid), .err_o(c_err), .rdata_o(c_rdata),
      .mem_req_o(c_mreq), .mem_we_o(c_mwe), .mem_be_o(c_mbe), .mem_addr_o(c_maddr),
      .mem_wdata_o(c_mwdata), .mem_rvalid_i(c_rv_p[2] | c_spur), .mem_rdata_i(c_rd_p[2]),
      .protocol_err_o(c_perr));

   // ---------------- RAM models (not reset, like the real macro) ----------------
   always @(posedge clk) begin : ram_a_model
      logic [31:0] tmp;
      a_mrvalid <= a_mreq;
      if (a_mreq) begin
         if (a_mwe) begin
            tmp = ram_a[a_maddr[15:2]];
            for (int b = 0; b < 4; b++) if (a_mbe[b]) tmp[8*b +: 8] = a_mwdata[8*b +: 8];
            ram_a[a_maddr[15:2]] <= tmp;
            a_mrdata <= 32'hDEAD_BEEF;
         end else begin
            a_mrdata <= ram_a[a_maddr[15:2]];
         end
      end
   end

   always @(posedge clk) f_mrvalid <= f_mreq;

   always @(posedge clk) begin
      c_rv_p   <= {c_rv_p[1:0], c_mreq};
      c_rd_p[0] <= c_mwe ? 32'hDEAD_BEEF : ram_c[c_maddr[15:2]];
      c_rd_p[1] <= c_rd_p[0];
      c_rd_p[2] <= c_rd_p[1];
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin : mon_a
      resp_t e;
      if (exp_a.size() > 0 && exp_a[0].due == 32'(cyc)) begin
         e = exp_a.pop_front();
         check("resp_a", {a_rvalid, a_err, a_rdata}, {e.rv, e.err, e.rdata});
      end else if (a_rvalid !== 3'b000) begin
         check("unexpected_rvalid_a", a_rvalid, 3'b000);
      end
   end

   always @(negedge clk) begin : mon_c
      resp_t e;
      if (exp_c.size() > 0 && exp_c[0].due == 32'(cyc)) begin
         e = exp_c.pop_front();
         check("resp_c", {c_rvalid, c_err, c_rdata}, {e.rv, e.err, e.rdata});
      end else if (c_rvalid !== 3'b000) begin
         check("unexpected_rvalid_c", c_rvalid, 3'b000);
      end
   end

   // ---------------- drivers ----------------
   function automatic vec_t mk(logic [2:0] rq, logic [2:0] w, logic [3:0] b,
                               logic [31:0] x0, logic [31:0] x1, logic [31:0] x2,
                               logic [31:0] d, logic [2:0] g, logic [2:0] fg, logic mr);
      return '{rq, w, b, x0, x1, x2, d, g, fg, mr};
   endfunction

   task automatic apply(input vec_t v);
      int w;
      logic [31:0] wa, old, exp_rd;
      @(posedge clk); #1;
      req = v.req; we = v.we; be = {3{v.be}};
      addr = {v.a2, v.a1, v.a0}; wdata = {3{v.wd}};
      @(negedge clk);
      check("gnt_rr", a_gnt, v.gnt);
      check("gnt_fp", f_gnt, v.fgnt);
      check("mem_req", a_mreq, v.mreq);
      if (v.gnt != 3'b000) begin
         w = (v.gnt == 3'b001) ? 0 : (v.gnt == 3'b010) ? 1 : 2;
         wa = addr[w*32 +: 32];
         if (v.mreq) begin
            check("mem_addr", a_maddr, wa);
            check("mem_we", a_mwe, v.we[w]);
            exp_rd = '0;
            if (v.we[w]) begin
               check("mem_be", a_mbe, v.be);
               check("mem_wdata", a_mwdata, v.wd);
               old = model_a[wa[15:2]];
               for (int b = 0; b < 4; b++) if (v.be[b]) old[8*b +: 8] = v.wd[8*b +: 8];
               model_a[wa[15:2]] = old;
            end else begin
               exp_rd = model_a[wa[15:2]];
            end
            exp_a.push_back('{rv: v.gnt, err: 3'b000, rdata: exp_rd, due: 32'(cyc + 1)});
         end else begin
            exp_a.push_back('{rv: v.gnt, err: v.gnt, rdata: 32'h0, due: 32'(cyc + 1)});
         end
      end
   endtask

   task automatic c_step(input logic [2:0] rq, input logic [2:0] exp_g, input logic [31:0] exp_rd,
                         input string name);
      @(posedge clk); #1;
      c_req = rq;
      @(negedge clk);
      check(name, c_gnt, exp_g);
      if (exp_g != 3'b000)
         exp_c.push_back('{rv: exp_g, err: 3'b000, rdata: exp_rd, due: 32'(cyc + 3)});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- test ----------------
   vec_t vecs[15];

   initial begin
      vecs[0]  = mk(3'b001, 3'b000, 4'hF, 32'h80, 32'h0, 32'h0, 32'h0, 3'b001, 3'b001, 1'b1);
      vecs[1]  = mk(3'b010, 3'b010, 4'hF, 32'h0, 32'h0001_0000, 32'h0, 32'h5555_5555,
                    3'b010, 3'b010, 1'b0);
      vecs[2]  = mk(3'b100, 3'b100, 4'b0101, 32'h0, 32'h0, 32'h100, 32'hAABB_CCDD,
                    3'b100, 3'b100, 1'b1);
      vecs[3]  = mk(3'b100, 3'b000, 4'hF, 32'h0, 32'h0, 32'h100, 32'h0, 3'b100, 3'b100, 1'b1);
      vecs[4]  = mk(3'b111, 3'b000, 4'hF, 32'h80, 32'h100, 32'h84, 32'h0, 3'b001, 3'b001, 1'b1);
      vecs[5]  = mk(3'b111, 3'b000, 4'hF, 32'h80, 32'h100, 32'h84, 32'h0, 3'b010, 3'b001, 1'b1);
      vecs[6]  = mk(3'b111, 3'b000, 4'hF, 32'h80, 32'h100, 32'h84, 32'h0, 3'b100, 3'b001, 1'b1);
      vecs[7]  = mk(3'b111, 3'b000, 4'hF, 32'h80, 32'h100, 32'h84, 32'h0, 3'b001, 3'b001, 1'b1);
      vecs[8]  = mk(3'b111, 3'b000, 4'hF, 32'h80, 32'h100, 32'h84, 32'h0, 3'b010, 3'b001, 1'b1);
      vecs[9]  = mk(3'b111, 3'b000, 4'hF, 32'h80, 32'h100, 32'h84, 32'h0, 3'b100, 3'b001, 1'b1);
      vecs[10] = mk(3'b010, 3'b000, 4'hF, 32'h0, 32'hFFFC, 32'h0, 32'h0, 3'b010, 3'b010, 1'b1);
      vecs[11] = mk(3'b001, 3'b000, 4'hF, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0,
                    3'b001, 3'b001, 1'b0);
      vecs[12] = mk(3'b000, 3'b000, 4'hF, 32'h80, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000, 1'b0);
      vecs[13] = mk(3'b101, 3'b000, 4'hF, 32'h80, 32'h0, 32'h84, 32'h0, 3'b100, 3'b001, 1'b1);
      vecs[14] = mk(3'b101, 3'b000, 4'hF, 32'h80, 32'h0, 32'h84, 32'h0, 3'b001, 3'b001, 1'b1);

      ram_a[14'h20] = 32'h0000_0013;   model_a[14'h20] = 32'h0000_0013;
      ram_a[14'h21] = 32'h2222_0021;   model_a[14'h21] = 32'h2222_0021;
      ram_a[14'h40] = 32'h1111_1111;   model_a[14'h40] = 32'h1111_1111;
      ram_a[14'h3FFF] = 32'hCAFE_F00D; model_a[14'h3FFF] = 32'hCAFE_F00D;
      ram_c[14'h20] = 32'h0000_0013;
      ram_c[14'h40] = 32'h1111_1111;

      // Reset with every requester asserting: all outputs must stay low
      rst_n = 1'b0; c_rst_n = 1'b0; c_spur = 1'b0;
      req = 3'b111; we = 3'b000; be = '1; addr = {3{32'h80}}; wdata = '0;
      c_req = 3'b111; c_we = 3'b000; c_be = '1; c_wdata = '0;
      c_addr = {32'h80, 32'h100, 32'h80};
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_gnt", a_gnt, 3'b000);
      check("rst_mem_req", a_mreq, 1'b0);
      check("rst_mem_addr", a_maddr, 32'h0);
      check("rst_rvalid", a_rvalid, 3'b000);
      check("rst_rdata", a_rdata, 32'h0);
      check("rst_perr", a_perr, 1'b0);
      check("rst_gnt_c", c_gnt, 3'b000);
      @(posedge clk); #1;
      rst_n = 1'b1; c_rst_n = 1'b1; req = 3'b000; c_req = 3'b000;

      for (int i = 0; i < 15; i++) apply(vecs[i]);
      @(posedge clk); #1;
      req = 3'b000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("queue_a_drained", 64'(exp_a.size()), 64'd0);
      check("perr_rr", a_perr, 1'b0);
      check("perr_fp", f_perr, 1'b0);

      // Latency 3: back-to-back instr then data reads
      c_step(3'b001, 3'b001, 32'h0000_0013, "l3_gnt_instr");
      c_step(3'b010, 3'b010, 32'h1111_1111, "l3_gnt_data");
      c_step(3'b000, 3'b000, 32'h0, "l3_idle");
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("queue_c_drained", 64'(exp_c.size()), 64'd0);
      check("l3_perr_clean", c_perr, 1'b0);

      // Spurious RAM response sets the sticky error
      @(posedge clk); #1; c_spur = 1'b1;
      @(posedge clk); #1; c_spur = 1'b0;
      @(negedge clk);
      check("l3_spurious_perr", c_perr, 1'b1);
      @(posedge clk); #1; c_rst_n = 1'b0;
      @(posedge clk); #1; c_rst_n = 1'b1;
      @(negedge clk);
      check("l3_perr_cleared", c_perr, 1'b0);

      // Two reads in flight, then reset: both responses vanish, pointer restarts
      @(posedge clk); #1; c_req = 3'b001;
      @(negedge clk); check("l3_inflight_0", c_gnt, 3'b001);
      @(posedge clk); #1; c_req = 3'b010;
      @(negedge clk); check("l3_inflight_1", c_gnt, 3'b010);
      @(posedge clk); #1; c_req = 3'b000; c_rst_n = 1'b0;
      @(posedge clk); #1; c_rst_n = 1'b1; c_req = 3'b111;
      @(negedge clk);
      check("l3_first_gnt_after_reset", c_gnt, 3'b001);
      exp_c.push_back('{rv: 3'b001, err: 3'b000, rdata: 32'h0000_0013, due: 32'(cyc + 3)});
      @(posedge clk); #1; c_req = 3'b000;
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("queue_c_after_reset", 64'(exp_c.size()), 64'd0);
      check("l3_perr_after_reset", c_perr, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
